// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential ROM reads, captures each
// response one cycle later into a small circular buffer, and hands the
// head entry to decode. A redirect flushes everything and restarts
// fetching at the (word-aligned) target.
// Optional feature: define IFQ_BYPASS_EN to forward an arriving ROM word
// straight to decode when the queue is empty (one-cycle fetch latency).
module ifetch_queue #(
  parameter int unsigned            XLEN     = 32,
  parameter int unsigned            DEPTH    = 4,
  parameter logic [XLEN-1:0]        RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       rom_ce_o,
  output logic [XLEN-1:0]            rom_addr_o,
  input  logic [31:0]                rom_data_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [31:0]                id_inst_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] flight_pc;
  logic            in_flight;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic [CW:0] occupancy;
  logic        issue;
  logic        arrive;
  logic        queue_empty;
  logic        bypass;
  logic        id_valid;
  logic        push;
  logic        pop;

  // Slot reservation counts the in-flight read, so a push always has room.
  // Gating with rst_n keeps the ROM idle for the whole reset interval and
  // lets the first fetch appear as soon as reset releases.
  always_comb begin
    occupancy   = {1'b0, count} + {{CW{1'b0}}, in_flight};
    issue       = rst_n && !redirect_i && (occupancy < DEPTH_W);
    arrive      = in_flight && !redirect_i;
    queue_empty = (count == '0);
`ifdef IFQ_BYPASS_EN
    bypass      = arrive && queue_empty;
`else
    bypass      = 1'b0;
`endif
    id_valid    = rst_n && !redirect_i && (!queue_empty || bypass);
    pop         = id_valid && id_ready_i && !queue_empty;
    // A bypassed word that decode accepts immediately never needs a slot.
    push        = arrive && !(bypass && id_ready_i);
  end

  // Decode-side output mux: head entry, bypassed response, or NOP filler.
  always_comb begin
    id_pc_o   = '0;
    id_inst_o = NOP;
    if (id_valid) begin
      id_pc_o   = pc_mem[head];
      id_inst_o = inst_mem[head];
`ifdef IFQ_BYPASS_EN
      if (bypass) begin
        id_pc_o   = flight_pc;
        id_inst_o = rom_data_i;
      end
`endif
    end
  end

  assign rom_ce_o   = issue;
  assign rom_addr_o = fetch_pc;
  assign id_valid_o = id_valid;
  assign count_o    = count;

  // Fetch PC, in-flight tracking, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      flight_pc <= '0;
      in_flight <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (redirect_i) begin
      fetch_pc  <= {redirect_pc_i[XLEN-1:2], 2'b00};
      in_flight <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        flight_pc <= fetch_pc;
        fetch_pc  <= fetch_pc + XLEN'(4);
      end
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= flight_pc;
      inst_mem[tail] <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4, XLEN=32, RESET_PC=0).
// The ROM model returns addr ^ 32'hA5A5_0000 one cycle after a read.
module tb_ifetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFQ_BYPASS_EN
  localparam int unsigned LAT        = 1;
  localparam int unsigned CNT_STEADY = 0;
`else
  localparam int unsigned LAT        = 2;
  localparam int unsigned CNT_STEADY = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int unsigned tests_run;
  int unsigned tests_failed;

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .rom_ce_o      (rom_ce),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the enabled read.
  always @(posedge clk) rom_data <= rom_ce ? (rom_addr ^ KEY) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves time mid-cycle in the first cycle after release.
  task automatic do_reset(input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = rdy;
    @(posedge clk);
    #1;
    check("rst_ce",    32'(rom_ce),   32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_count", 32'(count),    32'd0);
    check("rst_pc",    id_pc,         32'd0);
    check("rst_inst",  id_inst,       NOP);
    #2 rst_n = 1'b1;
    #1;
    check("rel_ce",   32'(rom_ce), 32'd1);
    check("rel_addr", rom_addr,    32'd0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    tests_run    = 0;
    tests_failed = 0;

    // Streaming with decode always ready.
    do_reset(1'b1);
    for (int unsigned k = 1; k <= 8; k++) begin
      step(1);
      check("strm_ce",   32'(rom_ce), 32'd1);
      check("strm_addr", rom_addr,    32'(4 * k));
      if (k < LAT) begin
        check("strm_nv",   32'(id_valid), 32'd0);
        check("strm_nvpc", id_pc,         32'd0);
        check("strm_nop",  id_inst,       NOP);
      end else begin
        check("strm_valid", 32'(id_valid), 32'd1);
        check("strm_pc",    id_pc,         32'(4 * (k - LAT)));
        check("strm_inst",  id_inst,       32'(4 * (k - LAT)) ^ KEY);
        check("strm_count", 32'(count),    CNT_STEADY);
      end
    end

    // Back-pressure: fill to DEPTH, then drain in order.
    do_reset(1'b0);
    step(4);
    check("stl_cnt3", 32'(count),  32'd3);
    check("stl_ce0",  32'(rom_ce), 32'd0);
    step(6);
    check("stl_cnt4",  32'(count),    32'd4);
    check("stl_ce0b",  32'(rom_ce),   32'd0);
    check("stl_valid", 32'(id_valid), 32'd1);
    check("stl_head",  id_pc,         32'd0);
    id_ready = 1'b1;
    exp_pc   = 32'd0;
    for (int unsigned i = 0; i < 12; i++) begin
      check("drn_valid", 32'(id_valid), 32'd1);
      check("drn_pc",    id_pc,         exp_pc);
      check("drn_inst",  id_inst,       exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      step(1);
    end

    // Redirect with 3 queued and one in flight.
    do_reset(1'b0);
    step(4);
    check("rd_pre_cnt", 32'(count),  32'd3);
    check("rd_pre_ce",  32'(rom_ce), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    check("rd_ce0",    32'(rom_ce),   32'd0);
    check("rd_valid0", 32'(id_valid), 32'd0);
    check("rd_nvpc",   id_pc,         32'd0);
    check("rd_nop",    id_inst,       NOP);
    step(1);
    redirect = 1'b0;
    id_ready = 1'b1;
    #1;
    check("rd_cnt0",  32'(count),    32'd0);
    check("rd_ce1",   32'(rom_ce),   32'd1);
    check("rd_addr",  rom_addr,      32'h0000_0100);
    check("rd_nv",    32'(id_valid), 32'd0);
    step(LAT);
    check("rd_hv",   32'(id_valid), 32'd1);
    check("rd_hpc",  id_pc,         32'h0000_0100);
    check("rd_hins", id_inst,       32'h0000_0100 ^ KEY);

    // Held redirect: last target wins, low bits cleared.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    step(1);
    redirect_pc = 32'h0000_0203;
    #1;
    check("rd2_ce0", 32'(rom_ce),   32'd0);
    check("rd2_v0",  32'(id_valid), 32'd0);
    step(1);
    redirect = 1'b0;
    #1;
    check("rd2_addr", rom_addr,    32'h0000_0200);
    check("rd2_ce",   32'(rom_ce), 32'd1);
    step(LAT);
    check("rd2_hpc", id_pc, 32'h0000_0200);

    // Fetch PC wraps modulo 2^32.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step(1);
    redirect = 1'b0;
    #1;
    check("wr_addr0", rom_addr, 32'hFFFF_FFFC);
    step(1);
    check("wr_addr1", rom_addr, 32'h0000_0000);
    step(LAT - 1);
    check("wr_pc0",  id_pc,   32'hFFFF_FFFC);
    check("wr_ins0", id_inst, 32'hFFFF_FFFC ^ KEY);
    step(1);
    check("wr_pc1",  id_pc,   32'h0000_0000);

    // Asynchronous reset mid-operation with 3 entries queued.
    do_reset(1'b0);
    step(4);
    check("ar_pre_cnt", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(id_valid), 32'd0);
    check("ar_ce",    32'(rom_ce),   32'd0);
    check("ar_cnt",   32'(count),    32'd0);
    check("ar_inst",  id_inst,       NOP);
    #2 rst_n = 1'b1;
    #1;
    check("ar_ce1",  32'(rom_ce), 32'd1);
    check("ar_addr", rom_addr,    32'd0);
    id_ready = 1'b1;
    step(LAT);
    check("ar_hv",  32'(id_valid), 32'd1);
    check("ar_hpc", id_pc,         32'd0);
    check("ar_cnt2", 32'(count),   CNT_STEADY);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (tests run %0d)", tests_run);
    $fatal(1);
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port redirect_i  input  1  branch/jump taken from EX; flush and refetch.
REQ-007 SHALL have port redirect_pc_i  input  XLEN  redirect target.
REQ-008 SHALL have port rom_ce_o  output  1  instruction ROM read enable.
REQ-009 SHALL have port rom_addr_o  output  XLEN  ROM read address.
REQ-010 SHALL have port rom_data_i  input  32  ROM data, valid one cycle after rom_ce_o=1.
REQ-011 SHALL have port id_valid_o  output  1  head entry valid for decode.
REQ-012 SHALL have port id_ready_i  input  1  decode accepts head.
REQ-013 SHALL have port id_pc_o  output  XLEN  PC of head entry.
REQ-014 SHALL have port id_inst_o  output  32  instruction of head entry.
REQ-015 SHALL have port count_o  output  clog2(DEPTH)+1  stored entries.

Function
REQ-016 SHALL issue a fetch (rom_ce_o=1, rom_addr_o=fetch PC) each cycle where count + in-flight < DEPTH and redirect_i=0; fetch PC then advances by 4, wrapping modulo 2^XLEN.
REQ-017 SHALL track at most one in-flight read and write {its PC, rom_data_i} at tail the cycle after issue.
REQ-018 SHALL pop head when id_valid_o && id_ready_i; push and pop in the same cycle leave count unchanged.
REQ-019 SHALL wrap head/tail pointers modulo DEPTH; never overwrite (reservation in REQ-016 guarantees space).
REQ-020 SHALL drive id_inst_o = 32'h0000_0013 (NOP) and id_pc_o = 0 whenever id_valid_o=0.
REQ-021 SHALL on redirect_i=1: force rom_ce_o=0 and id_valid_o=0 that cycle, discard any arriving response, set count 0 next cycle, load fetch PC with redirect_pc_i with bits [1:0] cleared.
REQ-022 SHALL issue the first redirect-target fetch the cycle after redirect_i; redirect_i held high repeats the flush, last target wins.
REQ-023 SHALL, without bypass, present a fetched word on id outputs no earlier than two cycles after its rom_ce_o cycle.

Reset
REQ-024 SHALL asynchronously on rst_n=0 clear count, pointers, in-flight flag; fetch PC = RESET_PC; rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=NOP, count_o=0.
REQ-025 SHALL assert rom_ce_o with rom_addr_o=RESET_PC in the first cycle after rst_n rises; reset mid-operation drops all queued and in-flight words.

Configuration
REQ-026 SHALL, with macro IFQ_BYPASS_EN defined, forward rom_data_i and its PC directly to id outputs when queue empty and response arriving (no redirect), skipping storage if id_ready_i=1 (else stored normally); fetch-to-decode latency one cycle.
REQ-027 SHALL, with IFQ_BYPASS_EN undefined, always store before presenting (latency per REQ-023); no combinational path rom_data_i to id outputs.

Verification
REQ-028 SHALL cover: reset release, RESET_PC=0, id_ready_i=1, ROM data=addr^32'hA5A5_0000 -> rom_addr_o 0,4,8,...; id_pc_o 0,4,8 with matching inst, one per cycle after fill (DEPTH=4).
REQ-029 SHALL cover: id_ready_i=0 for 10 cycles, DEPTH=4 -> count_o saturates at 4, rom_ce_o=0 once count+in-flight=4; on release PCs continue in order, none lost or duplicated.
REQ-030 SHALL cover: redirect_i with 3 entries queued and one in flight, target 0x100 -> count_o=0 next cycle, in-flight word dropped, next rom_addr_o=0x100, next id_pc_o=0x100.
REQ-031 SHALL cover: redirect target 0x203 -> rom_addr_o=0x200.
REQ-032 SHALL cover: rst_n low between edges with count_o=3 -> id_valid_o, rom_ce_o, count_o 0 immediately; after release fetch restarts at RESET_PC.
REQ-033 SHALL cover: empty queue, id_ready_i=1 -> id_valid_o one cycle after first rom_ce_o with IFQ_BYPASS_EN, two cycles without.
